// File: rtl/serdes_pkg.sv
// serdes_pkg: definitions shared by both ends of the serial link (s2p / p2s).
//   SER_LSB_FIRST / SER_MSB_FIRST : bit-order selectors for the LSB_FIRST parameter
//   ser_cw()                      : width of a bit counter that covers one word
package serdes_pkg;

  localparam bit SER_LSB_FIRST = 1'b1;
  localparam bit SER_MSB_FIRST = 1'b0;

  // Counter width for a DWIDTH-bit word. The floor of 1 keeps port widths
  // legal even for a degenerate width; that width is rejected elsewhere.
  function automatic int ser_cw(input int dwidth);
    return (dwidth < 2) ? 1 : $clog2(dwidth);
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// s2p_out_reg: one-entry output holding register with a valid/ready handshake.
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   load             a completed word is offered this cycle
//   word             the completed word
//   ready            the consumer accepts dout this cycle when dout_valid is high
//   dout, dout_valid the held word and its valid flag (registered)
//   overflow         one-cycle pulse: an offered word was dropped
module s2p_out_reg import serdes_pkg::*; #(
  parameter int DWIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DWIDTH-1:0] word,
  input  logic              ready,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  output logic              overflow
);

  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              accept_s;

  // Next-state of the holding register: a new word may replace an accepted one
  // in the same cycle, so back-to-back words see no bubble.
  always_comb begin
    accept_s   = valid_q & ready;
    dout_d     = dout_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    if (load && (!valid_q || accept_s)) begin
      dout_d  = word;
      valid_d = 1'b1;
    end else if (load) begin
      // Held word is still unconsumed: keep it, drop the new one.
      overflow_d = 1'b1;
    end else if (accept_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q     <= {DWIDTH{1'b0}};
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/s2p_deser.sv
// s2p_deser: serial-to-parallel deserializer, receive side of the serial link.
// Collects DWIDTH bits qualified by din_valid; sof restarts word alignment.
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   din, din_valid       serial bit and its qualifier (gaps allowed)
//   sof                  with din_valid: this bit is bit 0 of a new word
//   dout, dout_valid     parallel word and valid flag
//   dout_ready           consumer accepts dout this cycle
//   bit_cnt              bits collected in the current partial word
//   overflow             one-cycle pulse: a completed word was dropped
//   align_err            one-cycle pulse: sof discarded a non-empty partial word
module s2p_deser import serdes_pkg::*; #(
  parameter int DWIDTH    = 4,
  parameter bit LSB_FIRST = SER_LSB_FIRST,
  localparam int CW       = ser_cw(DWIDTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [DWIDTH-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CW-1:0]     bit_cnt,
  output logic              overflow,
  output logic              align_err
);

  generate
    if (DWIDTH < 2) begin : g_bad_dwidth
      $error("s2p_deser: DWIDTH must be >= 2");
    end
  endgenerate

  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     cnt_eff_s;
  logic              align_err_q, align_err_d;
  logic              completed_s;

  // Shift register and bit counter. sof forces the count to zero before the
  // bit is taken; stale shift bits need no clearing because a full word
  // overwrites every position before it is used.
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    align_err_d = 1'b0;
    completed_s = 1'b0;
    cnt_eff_s   = sof ? {CW{1'b0}} : bit_cnt_q;
    if (din_valid) begin
      if (LSB_FIRST == SER_LSB_FIRST) begin
        shift_d = {din, shift_q[DWIDTH-1:1]};
      end else begin
        shift_d = {shift_q[DWIDTH-2:0], din};
      end
      align_err_d = sof & (bit_cnt_q != {CW{1'b0}});
      if (cnt_eff_s == CW'(DWIDTH-1)) begin
        completed_s = 1'b1;
        bit_cnt_d   = {CW{1'b0}};
      end else begin
        bit_cnt_d   = cnt_eff_s + CW'(1'b1);
      end
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q     <= {DWIDTH{1'b0}};
      bit_cnt_q   <= {CW{1'b0}};
      align_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      align_err_q <= align_err_d;
    end
  end

  // The completed word includes the bit sampled this cycle, so it is taken
  // from shift_d rather than shift_q.
  s2p_out_reg #(
    .DWIDTH(DWIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rstn      (rstn),
    .load      (completed_s),
    .word      (shift_d),
    .ready     (dout_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .overflow  (overflow)
  );

  assign bit_cnt   = bit_cnt_q;
  assign align_err = align_err_q;

endmodule

// File: tb/tb_s2p_deser.sv
// Testbench for s2p_deser (DWIDTH=4). Two instances share the stimulus:
// one LSB-first, one MSB-first. A queue-based reference model tracks the
// received bits and the output register per the behavioural rules.
module tb_s2p_deser;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rstn, din, din_valid, sof, dout_ready;
  logic [DW-1:0] dout_l, dout_m;
  logic dval_l, dval_m, ovf_l, ovf_m, aerr_l, aerr_m;
  logic [1:0] cnt_l, cnt_m;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_bits[$];
  logic [DW-1:0] m_dout, m_dout_m;
  logic        m_valid, m_ovf, m_aerr;

  always #5 clk = ~clk;

  s2p_deser #(.DWIDTH(DW), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout_l), .dout_valid(dval_l), .dout_ready(dout_ready),
    .bit_cnt(cnt_l), .overflow(ovf_l), .align_err(aerr_l));

  s2p_deser #(.DWIDTH(DW), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rstn(rstn), .din(din), .din_valid(din_valid), .sof(sof),
    .dout(dout_m), .dout_valid(dval_m), .dout_ready(dout_ready),
    .bit_cnt(cnt_m), .overflow(ovf_m), .align_err(aerr_m));

  task automatic model_reset();
    m_bits.delete();
    m_dout = '0; m_dout_m = '0; m_valid = 1'b0; m_ovf = 1'b0; m_aerr = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic d, input logic v, input logic s, input logic r);
    logic acc, done;
    logic [DW-1:0] wl, wm;
    din = d; din_valid = v; sof = s; dout_ready = r;
    acc = m_valid & r; done = 1'b0; wl = '0; wm = '0;
    m_ovf = 1'b0; m_aerr = 1'b0;
    if (v) begin
      if (s) begin
        m_aerr = (m_bits.size() != 0);
        m_bits.delete();
      end
      m_bits.push_back(d);
      if (m_bits.size() == DW) begin
        done = 1'b1;
        for (int i = 0; i < DW; i++) begin
          wl[i]        = m_bits[i];
          wm[DW-1-i]   = m_bits[i];
        end
        m_bits.delete();
      end
    end
    if (done && (!m_valid || acc)) begin
      m_dout = wl; m_dout_m = wm; m_valid = 1'b1;
    end else if (done) begin
      m_ovf = 1'b1;
    end else if (acc) begin
      m_valid = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; din = 1'b0; din_valid = 1'b0; sof = 1'b0; dout_ready = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({dout_l, dval_l, cnt_l, ovf_l, aerr_l} !== 9'd0) begin
      n_fail++; $display("FAIL reset_state: got dout=%h v=%b cnt=%0d ovf=%b aerr=%b, want all 0",
                         dout_l, dval_l, cnt_l, ovf_l, aerr_l);
    end
    @(posedge clk); #1; rstn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (cnt_l !== 2'd2) begin n_fail++; $display("FAIL reset_midword_cnt: got %0d want 2", cnt_l); end
    rstn = 1'b0; model_reset(); #1;
    n_tests++;
    if ({dout_l, dval_l, cnt_l, ovf_l, aerr_l, dout_m, cnt_m} !== 15'd0) begin
      n_fail++; $display("FAIL reset_async: got dout=%h v=%b cnt=%0d ovf=%b aerr=%b, want all 0",
                         dout_l, dval_l, cnt_l, ovf_l, aerr_l);
    end
    @(posedge clk); #1; rstn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b1 || dout_l !== 4'hD) begin
      n_fail++; $display("FAIL reset_realign: got v=%b dout=%h want v=1 dout=d", dval_l, dout_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_continuous();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b0 || cnt_l !== 2'd3) begin
      n_fail++; $display("FAIL cont_partial: got v=%b cnt=%0d want v=0 cnt=3", dval_l, cnt_l);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b1 || dout_l !== 4'hD || dout_m !== 4'hB || cnt_l !== 2'd0) begin
      n_fail++; $display("FAIL cont_word: got v=%b dout=%h msb=%h cnt=%0d want 1 d b 0",
                         dval_l, dout_l, dout_m, cnt_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b0 || dout_l !== 4'hD) begin
      n_fail++; $display("FAIL cont_accept: got v=%b dout=%h want v=0 dout=d", dval_l, dout_l);
    end
  endtask

  task automatic test_gaps();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (cnt_l !== 2'd1) begin n_fail++; $display("FAIL gap_hold: got cnt=%0d want 1", cnt_l); end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b1 || dout_l !== 4'hD || dout_m !== 4'hB || aerr_l !== 1'b0) begin
      n_fail++; $display("FAIL gap_word: got v=%b dout=%h msb=%h aerr=%b want 1 d b 0",
                         dval_l, dout_l, dout_m, aerr_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (ovf_l !== 1'b0 || dout_l !== 4'hD) begin
      n_fail++; $display("FAIL ovf_early: got ovf=%b dout=%h want 0 d", ovf_l, dout_l);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (ovf_l !== 1'b1 || dout_l !== 4'hD || dval_l !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pulse: got ovf=%b dout=%h v=%b want 1 d 1", ovf_l, dout_l, dval_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (ovf_l !== 1'b0 || dout_l !== 4'hD) begin
      n_fail++; $display("FAIL ovf_once: got ovf=%b dout=%h want 0 d", ovf_l, dout_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b0 || dout_l !== 4'hD) begin
      n_fail++; $display("FAIL ovf_drain: got v=%b dout=%h want 0 d", dval_l, dout_l);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b1 || dout_l !== 4'hA || ovf_l !== 1'b0) begin
      n_fail++; $display("FAIL b2b_load: got v=%b dout=%h ovf=%b want 1 a 0", dval_l, dout_l, ovf_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (ovf_l !== 1'b0 || dval_l !== 1'b0) begin
      n_fail++; $display("FAIL b2b_after: got ovf=%b v=%b want 0 0", ovf_l, dval_l);
    end
  endtask

  task automatic test_sof_align();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (aerr_l !== 1'b1 || cnt_l !== 2'd1) begin
      n_fail++; $display("FAIL sof_aerr: got aerr=%b cnt=%0d want 1 1", aerr_l, cnt_l);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (aerr_l !== 1'b0 || dval_l !== 1'b0) begin
      n_fail++; $display("FAIL sof_partial: got aerr=%b v=%b want 0 0", aerr_l, dval_l);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    n_tests++;
    if (dval_l !== 1'b1 || dout_l !== 4'h3 || dout_m !== 4'hC) begin
      n_fail++; $display("FAIL sof_word: got v=%b dout=%h msb=%h want 1 3 c", dval_l, dout_l, dout_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic d, v, s, r;
    for (int i = 0; i < 600; i++) begin
      d = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 2) != 0);
      step(d, v, s, r);
      n_tests++;
      if (dout_l !== m_dout || dval_l !== m_valid || cnt_l !== 2'(m_bits.size()) ||
          ovf_l !== m_ovf || aerr_l !== m_aerr || dout_m !== m_dout_m || dval_m !== m_valid) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got dout=%h msb=%h v=%b cnt=%0d ovf=%b aerr=%b want %h %h %b %0d %b %b",
                 i, dout_l, dout_m, dval_l, cnt_l, ovf_l, aerr_l,
                 m_dout, m_dout_m, m_valid, m_bits.size(), m_ovf, m_aerr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_sof_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
